qcl_scratchpad_1pr2w_clr: RTL and testbench
===========================================

// Module: qcl_scratchpad_1pr2w_clr
// PURPOSE
//  Register-based scratchpad with two write ports, per-byte write masks and all entries
//  visible in parallel on data_o. Adds per-entry valid bits and a sweep-clear engine.
//  Two producers share one table read by downstream logic every cycle.
//  Stores are distributed RAM/flops; the clear engine occupies the table for els_p cycles.
// PARAMETERS
//  width_p     32  entry width in bits; must be a multiple of 8
//  els_p       16  number of entries; >=2; need not be a power of two
//  init_val_p  0   value written to every entry by a clear sweep (width_p bits)
//  addr_width_lp = $clog2(els_p), mask_width_lp = width_p/8 (localparams)
// PORTS
//  clk_i         in   1                      clock; all state updates on posedge
//  reset_i       in   1                      synchronous, active-high reset
//  clear_i       in   1                      request a sweep clear (sampled in IDLE only)
//  busy_o        out  1                      1 while in CLEAR state
//  w0_v_i        in   1                      port 0 write valid
//  w0_addr_i     in   addr_width_lp          port 0 entry index
//  w0_data_i     in   width_p                port 0 write data
//  w0_mask_i     in   mask_width_lp          port 0 byte enables (bit b -> data[8b+7:8b])
//  w0_ready_o    out  1                      port 0 ready
//  w1_v_i/w1_addr_i/w1_data_i/w1_mask_i/w1_ready_o   port 1, same widths/meaning
//  data_o        out  els_p x width_p        all stored entries, registered
//  valid_o       out  els_p                  per-entry written-since-clear flag
//  parity_err_o  out  els_p                  per-entry parity mismatch (see CONFIGURATION)
// BEHAVIOUR
//  - FSM states: CLEAR, IDLE. reset_i=1 -> state<=CLEAR, clr_ptr<=0, valid_o<=0.
//    While/after reset: busy_o=1, w*_ready_o=0. data_o undefined until sweep completes.
//  - CLEAR: each cycle entry[clr_ptr]<=init_val_p, valid_o[clr_ptr]<=0, clr_ptr++.
//    Cycle writing entry els_p-1 -> next state IDLE, clr_ptr<=0. Sweep = exactly els_p cycles.
//    clear_i ignored in CLEAR (no restart, no queueing).
//  - w0_ready_o = w1_ready_o = (state==IDLE); combinational from state only.
//  - IDLE: accepted write = w*_v_i & w*_ready_o. For each accepted write, bytes with
//    mask bit=1 update at posedge; visible on data_o the following cycle (1-cycle latency).
//    valid_o[addr]<=1 if accepted and mask != 0; mask==0 write is a no-op.
//  - Same address both ports: per-byte merge, port 1 wins on overlapping bytes.
//  - clear_i=1 in IDLE: that cycle's accepted writes still performed; state<=CLEAR next
//    cycle; busy_o=1 and ready=0 from next cycle; sweep overwrites everything.
//  - addr >= els_p (non-power-of-two els_p): write dropped, valid unchanged;
//    simulation-only $fatal on accepted out-of-range address.
//  - reset_i mid-sweep or mid-write: reset dominates; restarts sweep at entry 0.
// CONFIGURATION
//  QCL_SCRATCHPAD_PARITY_EN defined: one even-parity bit stored per entry, recomputed
//    over the full post-merge entry on every write and on clear. parity_err_o[i] =
//    valid_o[i] & (^entry[i] != par[i]); registered compare, 1-cycle latency after
//    the corrupting event.
//  Not defined: no parity storage; parity_err_o tied to 0.
// TESTING
//  1 reset 1 cycle, els_p=16 -> busy_o=1 for 16 cycles, then ready=1, valid_o=0,
//    all data_o=init_val_p.
//  2 w0 addr=3 data=32'hA1B2C3D4 mask=4'hF -> next cycle data_o[3]=A1B2C3D4, valid_o[3]=1.
//  3 same cycle w0 addr=5 data=11111111 mask=4'hF, w1 addr=5 data=22222222 mask=4'h3 ->
//    data_o[5]=32'h11112222.
//  4 clear_i with w1 addr=7 write same cycle -> data_o[7] updates, then busy 16 cycles;
//    writes offered during sweep see ready=0 and are not stored; end: valid_o=0.
//  5 reset_i at sweep cycle 8 -> sweep restarts at entry 0, busy_o=1 for 16 more cycles.
//  6 PARITY_EN: write then force a stored bit flip -> parity_err_o[i]=1 next cycle;
//    rewrite entry -> 0. Without macro parity_err_o stays 0.

Source files
------------

// File: rtl/qcl_scratchpad_1pr2w_clr.sv
// qcl_scratchpad_1pr2w_clr: register scratchpad, two masked write ports,
// all entries visible in parallel, per-entry valid bits and a sweep-clear
// engine that owns the table for els_p cycles after reset or clear_i.
// Optional feature macro: QCL_SCRATCHPAD_PARITY_EN (per-entry even parity).
module qcl_scratchpad_1pr2w_clr #(
  parameter int unsigned           width_p    = 32,
  parameter int unsigned           els_p      = 16,
  parameter logic [width_p-1:0]    init_val_p = '0,
  localparam int unsigned          addr_width_lp = $clog2(els_p),
  localparam int unsigned          mask_width_lp = width_p / 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        clear_i,
  output logic                        busy_o,

  input  logic                        w0_v_i,
  input  logic [addr_width_lp-1:0]    w0_addr_i,
  input  logic [width_p-1:0]          w0_data_i,
  input  logic [mask_width_lp-1:0]    w0_mask_i,
  output logic                        w0_ready_o,

  input  logic                        w1_v_i,
  input  logic [addr_width_lp-1:0]    w1_addr_i,
  input  logic [width_p-1:0]          w1_data_i,
  input  logic [mask_width_lp-1:0]    w1_mask_i,
  output logic                        w1_ready_o,

  output logic [els_p*width_p-1:0]    data_o,
  output logic [els_p-1:0]            valid_o,
  output logic [els_p-1:0]            parity_err_o
);

  typedef enum logic {CLEAR, IDLE} state_e;

  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

  state_e                     state_q, state_n;
  logic [addr_width_lp-1:0]   clr_ptr_q, clr_ptr_n;
  logic [els_p-1:0]           valid_q, valid_n;
  logic [width_p-1:0]         mem   [els_p];
  logic [width_p-1:0]         mem_n [els_p];
  logic                       w0_acc, w1_acc;

  assign w0_ready_o = (state_q == IDLE);
  assign w1_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q == CLEAR);
  assign valid_o    = valid_q;

  // Writes are gated by reset so an in-flight write cannot land while reset dominates.
  assign w0_acc = w0_v_i & w0_ready_o & ~reset_i;
  assign w1_acc = w1_v_i & w1_ready_o & ~reset_i;

  // State, sweep pointer and valid bits; reset restarts the sweep at entry 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_n;
      clr_ptr_q <= clr_ptr_n;
      valid_q   <= valid_n;
    end
  end

  // Next state: sweep one entry per cycle, leave after the last entry.
  always_comb begin
    state_n   = state_q;
    clr_ptr_n = clr_ptr_q;
    unique case (state_q)
      CLEAR: begin
        clr_ptr_n = clr_ptr_q + 1'b1;
        if (clr_ptr_q == last_addr_lp) begin
          state_n   = IDLE;
          clr_ptr_n = '0;
        end
      end
      IDLE: begin
        if (clear_i) state_n = CLEAR;
      end
      default: state_n = CLEAR;
    endcase
  end

`ifdef QCL_SCRATCHPAD_PARITY_EN
  logic [els_p-1:0] par_q, par_n;
  logic [els_p-1:0] par_err_q;
`endif

  // Next table contents: sweep entry in CLEAR; byte merge in IDLE with port 1 last so it wins.
  always_comb begin
    valid_n = valid_q;
`ifdef QCL_SCRATCHPAD_PARITY_EN
    par_n = par_q;
`endif
    for (int unsigned i = 0; i < els_p; i++) begin
      mem_n[i] = mem[i];
      if (state_q == CLEAR) begin
        if (clr_ptr_q == addr_width_lp'(i)) begin
          mem_n[i]   = init_val_p;
          valid_n[i] = 1'b0;
`ifdef QCL_SCRATCHPAD_PARITY_EN
          par_n[i]   = ^init_val_p;
`endif
        end
      end else begin
        for (int unsigned b = 0; b < mask_width_lp; b++) begin
          if (w0_acc && w0_addr_i == addr_width_lp'(i) && w0_mask_i[b])
            mem_n[i][8*b +: 8] = w0_data_i[8*b +: 8];
          if (w1_acc && w1_addr_i == addr_width_lp'(i) && w1_mask_i[b])
            mem_n[i][8*b +: 8] = w1_data_i[8*b +: 8];
        end
        if ((w0_acc && w0_addr_i == addr_width_lp'(i) && (|w0_mask_i)) ||
            (w1_acc && w1_addr_i == addr_width_lp'(i) && (|w1_mask_i))) begin
          valid_n[i] = 1'b1;
`ifdef QCL_SCRATCHPAD_PARITY_EN
          par_n[i]   = ^mem_n[i];
`endif
        end
      end
    end
  end

  // Table storage; no reset on data, the sweep provides the defined contents.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < els_p; i++) mem[i] <= mem_n[i];
    end
  end

  // Flatten the table onto data_o, entry i at bits [i*width_p +: width_p].
  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < els_p; i++) data_o[i*width_p +: width_p] = mem[i];
  end

`ifdef QCL_SCRATCHPAD_PARITY_EN
  // Parity bits follow the table; registered compare flags corrupted valid entries.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      par_err_q <= '0;
    end else begin
      par_q <= par_n;
      for (int unsigned i = 0; i < els_p; i++)
        par_err_q[i] <= valid_q[i] & ((^mem[i]) != par_q[i]);
    end
  end
  assign parity_err_o = par_err_q;
`else
  assign parity_err_o = '0;
`endif

`ifndef SYNTHESIS
  // Out-of-range accepted addresses are dropped by the decode; flag them in simulation.
  always_ff @(posedge clk_i) begin
    if (w0_acc && int'(w0_addr_i) >= int'(els_p))
      $fatal(1, "qcl_scratchpad_1pr2w_clr: w0 address out of range");
    if (w1_acc && int'(w1_addr_i) >= int'(els_p))
      $fatal(1, "qcl_scratchpad_1pr2w_clr: w1 address out of range");
  end
`endif

endmodule

// File: tb/tb_qcl_scratchpad_1pr2w_clr.sv
// Scoreboard bench for qcl_scratchpad_1pr2w_clr: stimulus queues expected
// values, a negedge monitor pops and compares them; busy-window lengths are
// compared whenever the DUT drops busy_o.
module tb_qcl_scratchpad_1pr2w_clr;

  localparam int unsigned W    = 32;
  localparam int unsigned N    = 16;
  localparam int unsigned AW   = 4;
  localparam logic [31:0] INIT = 32'h5A5A_0F0F;

  localparam int K_DATA = 0, K_VBIT = 1, K_READY = 2, K_BUSY = 3, K_PERR = 4, K_VALID = 5;

  logic            clk = 1'b0;
  logic            reset_i, clear_i, busy_o;
  logic            w0_v_i, w1_v_i, w0_ready_o, w1_ready_o;
  logic [AW-1:0]   w0_addr_i, w1_addr_i;
  logic [W-1:0]    w0_data_i, w1_data_i;
  logic [3:0]      w0_mask_i, w1_mask_i;
  logic [N*W-1:0]  data_o;
  logic [N-1:0]    valid_o, parity_err_o;

  qcl_scratchpad_1pr2w_clr #(.width_p(W), .els_p(N), .init_val_p(INIT)) dut (
    .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .busy_o(busy_o),
    .w0_v_i(w0_v_i), .w0_addr_i(w0_addr_i), .w0_data_i(w0_data_i),
    .w0_mask_i(w0_mask_i), .w0_ready_o(w0_ready_o),
    .w1_v_i(w1_v_i), .w1_addr_i(w1_addr_i), .w1_data_i(w1_data_i),
    .w1_mask_i(w1_mask_i), .w1_ready_o(w1_ready_o),
    .data_o(data_o), .valid_o(valid_o), .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   busy_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   busy_cnt = 0;
  bit   prev_busy = 0;

  // Monitor: pops queued expectations and busy-length expectations at negedge.
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    int          eb;
    if (reset_i === 1'b1) busy_cnt = 0;
    else if (busy_o === 1'b1) busy_cnt++;
    if (prev_busy && busy_o === 1'b0 && reset_i !== 1'b1) begin
      n_chk++;
      if (busy_q.size() == 0) begin
        n_err++;
        $display("FAIL busy_len: got unexpected busy window of %0d cycles, required none", busy_cnt);
      end else begin
        eb = busy_q.pop_front();
        if (busy_cnt != eb) begin
          n_err++;
          $display("FAIL busy_len: got %0d cycles, required %0d", busy_cnt, eb);
        end
      end
      busy_cnt = 0;
    end
    prev_busy = (busy_o === 1'b1);
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.kind)
        K_DATA:  act = data_o[c.idx*W +: W];
        K_VBIT:  act = {31'b0, valid_o[c.idx]};
        K_READY: act = {30'b0, w1_ready_o, w0_ready_o};
        K_BUSY:  act = {31'b0, busy_o};
        K_PERR:  act = {16'b0, parity_err_o};
        default: act = {16'b0, valid_o};
      endcase
      n_chk++;
      if (act !== c.exp) begin
        n_err++;
        $display("FAIL %s: got %h, required %h", c.name, act, c.exp);
      end
    end
  end

  task automatic chk(input string n, input int k, input int i, input logic [31:0] e);
    q.push_back('{name: n, kind: k, idx: i, exp: e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    w0_v_i = 0; w1_v_i = 0;
    w0_mask_i = '0; w1_mask_i = '0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    w0_v_i = 1; w0_addr_i = a; w0_data_i = d; w0_mask_i = m;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    w1_v_i = 1; w1_addr_i = a; w1_data_i = d; w1_mask_i = m;
  endtask

  task automatic wait_idle(input string n, input int max_cycles);
    int c = 0;
    while (w0_ready_o !== 1'b1 && c < max_cycles) begin
      tick();
      c++;
    end
    if (w0_ready_o !== 1'b1) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got ready=%b after %0d cycles, required 1", n, w0_ready_o, max_cycles);
    end
  endtask

  initial begin
    reset_i = 1; clear_i = 0;
    w0_addr_i = '0; w1_addr_i = '0; w0_data_i = '0; w1_data_i = '0;
    idle_ports();

    // 1: one-cycle reset, 16-cycle sweep, then table at init value.
    tick();
    reset_i = 0;
    busy_q.push_back(16);
    chk("reset_busy", K_BUSY, 0, 32'd1);
    chk("reset_ready", K_READY, 0, 32'd0);
    wait_idle("reset_sweep_end", 40);
    chk("idle_ready", K_READY, 0, 32'd3);
    chk("idle_valid", K_VALID, 0, 32'h0);
    chk("init_e0", K_DATA, 0, INIT);
    chk("init_e7", K_DATA, 7, INIT);
    chk("init_e15", K_DATA, 15, INIT);
    chk("init_perr", K_PERR, 0, 32'h0);
    tick();

    // 2: full write on port 0.
    wr0(3, 32'hA1B2C3D4, 4'hF);
    tick(); idle_ports();
    chk("w0_e3", K_DATA, 3, 32'hA1B2C3D4);
    chk("w0_v3", K_VBIT, 3, 32'd1);
    chk("w0_valid", K_VALID, 0, 32'h0008);
    tick();

    // 3: same address, port 1 wins overlapping low bytes.
    wr0(5, 32'h11111111, 4'hF);
    wr1(5, 32'h22222222, 4'h3);
    tick(); idle_ports();
    chk("merge_e5", K_DATA, 5, 32'h11112222);

    // Partial mask on init data; port 1 to the top entry.
    wr0(4, 32'hAABBCCDD, 4'b0101);
    wr1(15, 32'h0BADF00D, 4'hF);
    tick(); idle_ports();
    chk("partial_e4", K_DATA, 4, 32'h5ABB0FDD);
    chk("top_e15", K_DATA, 15, 32'h0BADF00D);

    // Zero mask is a no-op; single top byte on entry 0.
    wr0(10, 32'hFFFFFFFF, 4'h0);
    wr1(0, 32'h77000000, 4'b1000);
    tick(); idle_ports();
    chk("mask0_v10", K_VBIT, 10, 32'd0);
    chk("mask0_e10", K_DATA, 10, INIT);
    chk("byte3_e0", K_DATA, 0, 32'h775A0F0F);
    chk("valid_mix", K_VALID, 0, 32'h8039);

    // Full overlap: port 1 wins every byte.
    wr0(6, 32'h12345678, 4'hF);
    wr1(6, 32'h9ABCDEF0, 4'hF);
    tick(); idle_ports();
    chk("overlap_e6", K_DATA, 6, 32'h9ABCDEF0);
    chk("overlap_valid", K_VALID, 0, 32'h8079);
    chk("perr_idle", K_PERR, 0, 32'h0);
    tick();

`ifdef QCL_SCRATCHPAD_PARITY_EN
    // 6: corrupt a stored bit, expect a flag, rewrite clears it.
    wr0(2, 32'h000000FF, 4'hF);
    tick(); idle_ports();
    tick();
    chk("par_clean", K_PERR, 0, 32'h0);
    dut.mem[2] = 32'h000000FE;
    tick();
    chk("par_flip", K_PERR, 0, 32'h0004);
    wr0(2, 32'h000000FF, 4'hF);
    tick(); idle_ports();
    tick();
    chk("par_rewrite", K_PERR, 0, 32'h0);
`endif

    // 4: clear with a same-cycle write; writes during the sweep are refused.
    wr1(7, 32'hCAFEF00D, 4'hF);
    clear_i = 1;
    busy_q.push_back(16);
    tick(); idle_ports(); clear_i = 0;
    chk("clr_e7", K_DATA, 7, 32'hCAFEF00D);
    chk("clr_v7", K_VBIT, 7, 32'd1);
    chk("clr_busy", K_BUSY, 0, 32'd1);
    chk("clr_ready", K_READY, 0, 32'd0);
    wr0(9, 32'h13579BDF, 4'hF);
    clear_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sweep_ready", K_READY, 0, 32'd0);
    end
    idle_ports(); clear_i = 0;
    wait_idle("clear_sweep_end", 40);
    chk("clr_valid", K_VALID, 0, 32'h0);
    chk("clr_e9", K_DATA, 9, INIT);
    chk("clr_e7_end", K_DATA, 7, INIT);
    chk("clr_e3_end", K_DATA, 3, INIT);
    tick();

    // 5: reset at sweep cycle 8 restarts a full sweep.
    wr0(2, 32'h00000011, 4'hF);
    tick(); idle_ports();
    chk("pre_e2", K_DATA, 2, 32'h00000011);
    clear_i = 1;
    tick(); clear_i = 0;
    for (int i = 0; i < 8; i++) tick();
    reset_i = 1;
    tick(); reset_i = 0;
    busy_q.push_back(16);
    for (int i = 0; i < 10; i++) tick();
    chk("rst_mid_busy", K_BUSY, 0, 32'd1);
    wait_idle("reset_mid_end", 40);
    chk("rst_valid", K_VALID, 0, 32'h0);
    chk("rst_e2", K_DATA, 2, INIT);
    chk("rst_perr", K_PERR, 0, 32'h0);
    tick();
    tick();

    n_chk++;
    if (busy_q.size() != 0) begin
      n_err++;
      $display("FAIL busy_pending: got %0d unseen busy windows, required 0", busy_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
